// File: rtl/zxw_seg_monitor_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : zxw_seg_pkg
//  Description : Shared constants for the seven-segment monitor. Contains the
//                glyph table, the FIFO entry layout, the filter state codes
//                and the pattern decode helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package zxw_seg_pkg;

  // FIFO entry layout: {err, blank, dp, digit[3:0]}
  localparam int ENT_W         = 7;
  localparam int ENT_DIGIT_LSB = 0;
  localparam int ENT_DP        = 4;
  localparam int ENT_BLANK     = 5;
  localparam int ENT_ERR       = 6;

  // Active-low {g..a}; all seven segments dark
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g..a} glyphs, index 15 first so that SEG_GLYPH[i] is digit i
  localparam logic [15:0][6:0] SEG_GLYPH = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

  // Filter state encodings
  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_QUALIFY = 1'b1;

  // Classify an active-low {dp,g..a} pattern into a FIFO entry
  function automatic logic [ENT_W-1:0] seg_decode(input logic [7:0] seg);
    logic [ENT_W-1:0] e;
    e         = '0;
    e[ENT_DP] = ~seg[7];
    if (seg[6:0] == SEG_BLANK) begin
      e[ENT_BLANK] = 1'b1;
    end else begin
      e[ENT_ERR] = 1'b1;
      for (int i = 0; i < 16; i++) begin
        if (seg[6:0] == SEG_GLYPH[i]) begin
          e[ENT_ERR]                  = 1'b0;
          e[ENT_DIGIT_LSB +: 4]       = 4'(i);
        end
      end
    end
    return e;
  endfunction

endpackage
`default_nettype wire

// File: rtl/zxw_seg_monitor_if.sv
`default_nettype none
// ============================================================================
//  Module      : zxw_seg_monitor_if
//  Description : Segment bus in, decoded status and FIFO readback out.
//                master = display/readout side, slave = monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
interface zxw_seg_monitor_if;
  import zxw_seg_pkg::*;

  logic [7:0]       Seg_in;
  logic             Rd_en;
  logic [3:0]       Digit_out;
  logic             Dp_out;
  logic             Valid_out;
  logic             Blank_out;
  logic             Error_out;
  logic [ENT_W-1:0] Rd_data;
  logic             Fifo_empty;
  logic             Fifo_full;
  logic             Overflow;
  logic [7:0]       Change_count;

  modport master (
    output Seg_in, Rd_en,
    input  Digit_out, Dp_out, Valid_out, Blank_out, Error_out,
    input  Rd_data, Fifo_empty, Fifo_full, Overflow, Change_count
  );

  modport slave (
    input  Seg_in, Rd_en,
    output Digit_out, Dp_out, Valid_out, Blank_out, Error_out,
    output Rd_data, Fifo_empty, Fifo_full, Overflow, Change_count
  );
endinterface
`default_nettype wire

// File: rtl/zxw_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : zxw_sync_fifo
//  Description : Single-clock first-word-fall-through FIFO. A push while full
//                is accepted only when a pop happens in the same cycle. Head
//                reads as zero when empty.
//  Revision    : 1.0 - initial release
// ============================================================================
module zxw_sync_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 7
) (
  input  wire logic             clk,
  input  wire logic             rst,
  input  wire logic             i_push,
  input  wire logic             i_pop,
  input  wire logic [WIDTH-1:0] i_data,
  output logic      [WIDTH-1:0] o_data,
  output logic                  o_empty,
  output logic                  o_full
);
  localparam int             c_AW  = $clog2(DEPTH);
  localparam logic [c_AW:0]  c_ONE = (c_AW+1)'(1);

  logic [c_AW:0]      r_wr_ptr;
  logic [c_AW:0]      r_rd_ptr;
  logic [WIDTH-1:0]   r_mem [DEPTH];
  logic               w_do_push;
  logic               w_do_pop;

  assign o_empty   = (r_wr_ptr == r_rd_ptr);
  assign o_full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
  assign w_do_push = i_push && (!o_full || i_pop);
  assign w_do_pop  = i_pop && !o_empty;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr[c_AW-1:0]];

  // Storage write; contents are don't-care until a pointer covers them
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[c_AW-1:0]] <= i_data;
  end

  // Pointer advance; extra MSB distinguishes full from empty
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + c_ONE;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + c_ONE;
    end
  end
endmodule
`default_nettype wire

// File: rtl/zxw_seg_monitor.sv
`default_nettype none
// ============================================================================
//  Module      : zxw_seg_monitor
//  Description : Synchronises and debounces an active-low seven-segment bus,
//                decodes the accepted pattern to hex digit / dp / class, and
//                logs every accepted change into a readback FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
module zxw_seg_monitor
  import zxw_seg_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,
  parameter int DEPTH         = 8
) (
  input  wire logic          Clock,
  input  wire logic          Reset,
  zxw_seg_monitor_if.slave   bus
);
  localparam logic [8:0] c_stable = 9'(STABLE_CYCLES);

  logic [7:0]       r_sync1;
  logic [7:0]       r_sync2;
  logic [0:0]       r_state;
  logic [7:0]       r_cand;
  logic [7:0]       r_cnt;
  logic [7:0]       r_acc;
  logic             r_evt;
  logic [3:0]       r_digit;
  logic             r_dp;
  logic             r_valid;
  logic             r_blank;
  logic             r_err;
  logic [7:0]       r_count;
  logic             r_ovf;

  logic [0:0]       w_state_nxt;
  logic [7:0]       w_cand_nxt;
  logic [7:0]       w_cnt_nxt;
  logic [8:0]       w_cnt_inc;
  logic             w_hit;
  logic             w_accept;
  logic [ENT_W-1:0] w_dec;
  logic             w_full;
  logic             w_empty;
  logic [ENT_W-1:0] w_rd_data;

  assign w_cnt_inc = {1'b0, r_cnt} + 9'd1;
  assign w_hit     = (w_cnt_inc == c_stable);
  assign w_dec     = seg_decode(r_acc);

  // Two-flop synchroniser on the raw segment bus
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sync1 <= 8'hFF;
      r_sync2 <= 8'hFF;
    end else begin
      r_sync1 <= bus.Seg_in;
      r_sync2 <= r_sync1;
    end
  end

  // Filter state register together with candidate, counter and accepted pattern
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= ST_IDLE;
      r_cand  <= 8'hFF;
      r_cnt   <= 8'd0;
      r_acc   <= 8'hFF;
      r_evt   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_evt   <= w_accept;
      if (w_accept) r_acc <= r_sync2;
    end
  end

  // Next-state: restart qualification whenever the synchronised value moves
  always_comb begin
    w_state_nxt = r_state;
    w_cand_nxt  = r_cand;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (r_sync2 != r_acc) begin
          w_cand_nxt = r_sync2;
          if (c_stable == 9'd1) begin
            w_cnt_nxt = 8'd0;
          end else begin
            w_cnt_nxt   = 8'd1;
            w_state_nxt = ST_QUALIFY;
          end
        end
      end
      ST_QUALIFY: begin
        if (r_sync2 == r_cand) begin
          if (w_hit) begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = 8'd0;
          end else begin
            w_cnt_nxt = w_cnt_inc[7:0];
          end
        end else if (r_sync2 == r_acc) begin
          w_state_nxt = ST_IDLE;
          w_cand_nxt  = r_sync2;
          w_cnt_nxt   = 8'd0;
        end else begin
          w_cand_nxt = r_sync2;
          w_cnt_nxt  = 8'd1;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = 8'd0;
      end
    endcase
  end

  // Output: acceptance fires on the cycle the stable count is reached
  always_comb begin
    w_accept = 1'b0;
    case (r_state)
      ST_IDLE:    w_accept = (r_sync2 != r_acc) && (c_stable == 9'd1);
      ST_QUALIFY: w_accept = (r_sync2 == r_cand) && w_hit;
      default:    w_accept = 1'b0;
    endcase
  end

  // Registered decode of the accepted pattern
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_digit <= 4'd0;
      r_dp    <= 1'b0;
      r_valid <= 1'b0;
      r_blank <= 1'b1;
      r_err   <= 1'b0;
    end else begin
      r_digit <= w_dec[ENT_DIGIT_LSB +: 4];
      r_dp    <= w_dec[ENT_DP];
      r_blank <= w_dec[ENT_BLANK];
      r_err   <= w_dec[ENT_ERR];
      r_valid <= ~w_dec[ENT_BLANK] & ~w_dec[ENT_ERR];
    end
  end

  // Saturating change counter and sticky drop flag
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_count <= 8'd0;
      r_ovf   <= 1'b0;
    end else begin
      if (r_evt && (r_count != 8'hFF)) r_count <= r_count + 8'd1;
      if (r_evt && w_full && !bus.Rd_en) r_ovf <= 1'b1;
    end
  end

  zxw_sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (Clock),
    .rst     (Reset),
    .i_push  (r_evt),
    .i_pop   (bus.Rd_en),
    .i_data  (w_dec),
    .o_data  (w_rd_data),
    .o_empty (w_empty),
    .o_full  (w_full)
  );

  assign bus.Digit_out    = r_digit;
  assign bus.Dp_out       = r_dp;
  assign bus.Valid_out    = r_valid;
  assign bus.Blank_out    = r_blank;
  assign bus.Error_out    = r_err;
  assign bus.Rd_data      = w_rd_data;
  assign bus.Fifo_empty   = w_empty;
  assign bus.Fifo_full    = w_full;
  assign bus.Overflow     = r_ovf;
  assign bus.Change_count = r_count;
endmodule
`default_nettype wire

// File: tb/tb_zxw_seg_monitor.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module      : tb_zxw_seg_monitor
//  Description : Self-checking bench for zxw_seg_monitor (STABLE_CYCLES=4,
//                DEPTH=8, 40 ns clock). Vector table plus scoreboard queue of
//                expected FIFO entries.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_zxw_seg_monitor;
  logic clk = 1'b0;
  logic rst;

  always #20 clk = ~clk;

  zxw_seg_monitor_if bus ();

  zxw_seg_monitor #(
    .STABLE_CYCLES (4),
    .DEPTH         (8)
  ) dut (
    .Clock (clk),
    .Reset (rst),
    .bus   (bus)
  );

  typedef struct {
    logic [7:0] seg;
    logic [3:0] digit;
    logic       dp;
    logic       valid;
    logic       blank;
    logic       err;
    logic [6:0] entry;
  } vec_t;

  vec_t       vecs [8];
  logic [6:0] glyph [16];
  logic [6:0] q [$];
  int         n_tests = 0;
  int         n_fail  = 0;
  int         count_exp = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_dec(input string name, input logic [3:0] d, input logic dp,
                           input logic v, input logic b, input logic e);
    chk({name, "_digit"}, bus.Digit_out, d);
    chk({name, "_dp"},    bus.Dp_out,    dp);
    chk({name, "_valid"}, bus.Valid_out, v);
    chk({name, "_blank"}, bus.Blank_out, b);
    chk({name, "_err"},   bus.Error_out, e);
  endtask

  task automatic check_reset(input string name);
    check_dec(name, 4'd0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk({name, "_rd_data"}, bus.Rd_data,      0);
    chk({name, "_empty"},   bus.Fifo_empty,   1);
    chk({name, "_full"},    bus.Fifo_full,    0);
    chk({name, "_ovf"},     bus.Overflow,     0);
    chk({name, "_count"},   bus.Change_count, 0);
  endtask

  // Compare FIFO head against the scoreboard, then pop for one cycle
  task automatic do_pop();
    logic [6:0] e;
    if (q.size() == 0) begin
      n_tests++;
      n_fail++;
      $display("FAIL pop_underflow: scoreboard empty at %0t", $time);
    end else begin
      e = q.pop_front();
      chk("rd_data", bus.Rd_data, e);
    end
    bus.Rd_en = 1'b1;
    edges(1);
    bus.Rd_en = 1'b0;
  endtask

  task automatic step(input logic [7:0] seg);
    bus.Seg_in = seg;
    edges(7);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    glyph = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
    //           seg    digit  dp    valid blank err   entry
    vecs[0] = '{8'hFF, 4'h0, 1'b0, 1'b0, 1'b1, 1'b0, 7'h20};
    vecs[1] = '{8'hC0, 4'h0, 1'b0, 1'b1, 1'b0, 1'b0, 7'h00};
    vecs[2] = '{8'hF9, 4'h1, 1'b0, 1'b1, 1'b0, 1'b0, 7'h01};
    vecs[3] = '{8'h24, 4'h2, 1'b1, 1'b1, 1'b0, 1'b0, 7'h12};
    vecs[4] = '{8'hB0, 4'h3, 1'b0, 1'b1, 1'b0, 1'b0, 7'h03};
    vecs[5] = '{8'h7F, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0, 7'h30};
    vecs[6] = '{8'hFE, 4'h0, 1'b0, 1'b0, 1'b0, 1'b1, 7'h40};
    vecs[7] = '{8'h8E, 4'hF, 1'b0, 1'b1, 1'b0, 1'b0, 7'h0F};

    rst        = 1'b1;
    bus.Seg_in = 8'h00;
    bus.Rd_en  = 1'b0;
    edges(3);
    check_reset("reset");

    // Release with 00 on the bus: digit 8 with dp exactly 7 edges later
    rst = 1'b0;
    edges(6);
    chk("early_blank", bus.Blank_out, 1);
    chk("early_count", bus.Change_count, 0);
    edges(1);
    check_dec("first", 4'd8, 1'b1, 1'b1, 1'b0, 1'b0);
    count_exp = 1;
    chk("first_count", bus.Change_count, count_exp);
    chk("first_empty", bus.Fifo_empty, 0);
    q.push_back(7'h18);
    do_pop();
    chk("first_drained", bus.Fifo_empty, 1);

    // Table of single changes, each logged and read back
    for (int i = 0; i < 8; i++) begin
      step(vecs[i].seg);
      check_dec("vec", vecs[i].digit, vecs[i].dp, vecs[i].valid, vecs[i].blank, vecs[i].err);
      count_exp++;
      chk("vec_count", bus.Change_count, count_exp);
      chk("vec_empty", bus.Fifo_empty, 0);
      q.push_back(vecs[i].entry);
      do_pop();
      chk("vec_drained", bus.Fifo_empty, 1);
    end

    // Glitch of 3 cycles must not be accepted
    step(8'hC0);
    count_exp++;
    q.push_back(7'h00);
    do_pop();
    bus.Seg_in = 8'hF9;
    edges(3);
    bus.Seg_in = 8'hC0;
    edges(12);
    chk("glitch_count", bus.Change_count, count_exp);
    chk("glitch_empty", bus.Fifo_empty, 1);
    check_dec("glitch", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);

    // Sixteen glyphs without reading: first 8 kept, rest dropped
    step(8'h7F);
    count_exp++;
    q.push_back(7'h30);
    do_pop();
    for (int g = 0; g < 16; g++) begin
      step({1'b1, glyph[g]});
      count_exp++;
      if (g < 8) q.push_back(7'(g));
    end
    chk("ovf_full",  bus.Fifo_full, 1);
    chk("ovf_flag",  bus.Overflow, 1);
    chk("ovf_count", bus.Change_count, count_exp);
    for (int k = 0; k < 8; k++) do_pop();
    chk("ovf_drained", bus.Fifo_empty, 1);

    // Reset in the middle of qualification, checked before any clock edge
    bus.Seg_in = 8'h24;
    edges(4);
    rst        = 1'b1;
    bus.Seg_in = 8'hFF;
    #5;
    check_reset("midq_async");
    q.delete();
    edges(2);
    rst = 1'b0;
    edges(10);
    check_reset("midq_after");
    count_exp = 0;

    // Fill, then change event coinciding with a pop while full
    for (int g = 0; g < 8; g++) begin
      step({1'b1, glyph[g]});
      count_exp++;
      q.push_back(7'(g));
    end
    chk("fill_full", bus.Fifo_full, 1);
    chk("fill_ovf",  bus.Overflow, 0);
    bus.Seg_in = {1'b1, glyph[8]};
    edges(6);
    do_pop();
    count_exp++;
    q.push_back(7'h08);
    chk("simul_full",  bus.Fifo_full, 1);
    chk("simul_ovf",   bus.Overflow, 0);
    chk("simul_count", bus.Change_count, count_exp);
    check_dec("simul", 4'd8, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 8; k++) do_pop();
    chk("simul_drained", bus.Fifo_empty, 1);
    chk("simul_rd_zero", bus.Rd_data, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
